// File: rtl/multi_clk_div.sv
// NUM_CH independent programmable clock dividers with glitch-free enable, period-boundary divisor updates and global sync.
// clk_out/tick are registered from the same edge as the phase counter; there is no backpressure.
module multi_clk_div #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic                    clk_in1,
    input  logic                    rst,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       cfg_pending
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pend_div_q, pend_div_d;
        logic             active_q, active_d;
        logic             pending_q, pending_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic [DIV_W-1:0] load_val;
        logic [DIV_W:0]   half;
        logic             wrap;

        always_comb begin
            load_val = div_cfg[g*DIV_W +: DIV_W];
            if (load_val < DIV_W'(2)) begin
                load_val = DIV_W'(2);
            end

            cnt_d      = cnt_q;
            div_d      = div_q;
            active_d   = active_q;
            pend_div_d = cfg_load[g] ? load_val : pend_div_q;
            pending_d  = pending_q | cfg_load[g];
            wrap       = (cnt_q == div_q - DIV_W'(1));

            if (!active_q) begin
                // An idle channel has no boundary to wait for, so the divisor applies immediately.
                if (cfg_load[g]) begin
                    div_d = load_val;
                end
                pending_d = cfg_load[g];
                if (ch_en[g]) begin
                    active_d = 1'b1;
                    cnt_d    = '0;
                end
            end else if (sync) begin
                cnt_d = '0;
                if (pending_q) begin
                    div_d = pend_div_q;
                end
                pending_d = cfg_load[g];
            end else if (wrap) begin
                // A load landing on this edge stays pending for the following wrap.
                cnt_d = '0;
                if (pending_q) begin
                    div_d = pend_div_q;
                end
                pending_d = cfg_load[g];
                active_d  = ch_en[g];
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            half   = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
            clk_d  = active_d && ({1'b0, cnt_d} < half);
            tick_d = active_d && (cnt_d == div_d - DIV_W'(1));
        end

        always_ff @(posedge clk_in1 or posedge rst) begin
            if (rst) begin
                cnt_q      <= '0;
                div_q      <= DIV_W'(RESET_DIV);
                pend_div_q <= DIV_W'(RESET_DIV);
                active_q   <= 1'b0;
                pending_q  <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                pend_div_q <= pend_div_d;
                active_q   <= active_d;
                pending_q  <= pending_d;
                clk_q      <= clk_d;
                tick_q     <= tick_d;
            end
        end

        assign clk_out[g]     = clk_q;
        assign tick[g]        = tick_q;
        assign cfg_pending[g] = pending_q;
    end

endmodule
